// File: rtl/timing_constants.sv
// WS2812 cycle constants shared by encoder and decoder, plus encoder FSM state type.
// Latency: n/a (package); backpressure: n/a.
package timing_constants;

  typedef struct packed {
    logic [31:0] t0h;
    logic [31:0] t1h;
    logic [31:0] t0l;
    logic [31:0] t1l;
    logic [31:0] treset;
  } timing_params_encode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    LATCH = 2'd3
  } enc_state_t;

  function automatic timing_params_encode_t init_encode_params();
    timing_params_encode_t p;
    p.t0h    = 32'd7;
    p.t1h    = 32'd14;
    p.t0l    = 32'd16;
    p.t1l    = 32'd12;
    p.treset = 32'd1000;
    return p;
  endfunction

  localparam timing_params_encode_t ENC_DEFAULTS = init_encode_params();

endpackage

// File: rtl/ws2812_phase_timer.sv
// Loadable down-counter timing HIGH, LOW and LATCH phases; done while count is 0.
// Latency: load takes effect next cycle; no backpressure.
module ws2812_phase_timer #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  input  logic         i_tick,
  output logic         o_done
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_tick && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/ws2812_encoder.sv
// Serialises 24-bit pixels MSB first into a WS2812 NRZ stream; dout rises the cycle after accept.
// s_ready only in IDLE or the final LOW cycle of a non-last pixel. Option: GRB_REORDER_EN (input is RGB).
module ws2812_encoder
  import timing_constants::*;
#(
  parameter int unsigned T0H_CYCLES    = ENC_DEFAULTS.t0h,
  parameter int unsigned T1H_CYCLES    = ENC_DEFAULTS.t1h,
  parameter int unsigned T0L_CYCLES    = ENC_DEFAULTS.t0l,
  parameter int unsigned T1L_CYCLES    = ENC_DEFAULTS.t1l,
  parameter int unsigned TRESET_CYCLES = ENC_DEFAULTS.treset
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] s_pixel,
  input  logic        s_last,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        dout,
  output logic        busy
);

  localparam int unsigned MAX_H = (T1H_CYCLES > T0H_CYCLES) ? T1H_CYCLES : T0H_CYCLES;
  localparam int unsigned MAX_L = (T1L_CYCLES > T0L_CYCLES) ? T1L_CYCLES : T0L_CYCLES;
  localparam int unsigned MAX_B = (MAX_H > MAX_L) ? MAX_H : MAX_L;
  localparam int unsigned MAX_T = (MAX_B > TRESET_CYCLES) ? MAX_B : TRESET_CYCLES;
  localparam int unsigned CW    = $clog2(MAX_T + 1);

  // Timer is loaded with N-1 so a phase of N cycles ends on the cycle the count reads 0.
  localparam logic [CW-1:0] L_T0H = CW'(T0H_CYCLES - 1);
  localparam logic [CW-1:0] L_T1H = CW'(T1H_CYCLES - 1);
  localparam logic [CW-1:0] L_T0L = CW'(T0L_CYCLES - 1);
  localparam logic [CW-1:0] L_T1L = CW'(T1L_CYCLES - 1);
  localparam logic [CW-1:0] L_TRS = CW'(TRESET_CYCLES - 1);

  if (T0H_CYCLES == 0 || T1H_CYCLES <= T0H_CYCLES || T0L_CYCLES < 2 ||
      T1L_CYCLES < 2 || TRESET_CYCLES == 0) begin : g_param_check
    $error("ws2812_encoder: invalid timing parameters");
  end

  enc_state_t    r_state;
  enc_state_t    w_next;
  logic [23:0]   r_shreg;
  logic [23:0]   w_pix;
  logic [4:0]    r_bit_idx;
  logic          r_last;
  logic          r_dout;
  logic          w_load;
  logic [CW-1:0] w_value;
  logic          w_done;
  logic          w_pix_end;
  logic          w_xfer;

`ifdef GRB_REORDER_EN
  assign w_pix = {s_pixel[15:8], s_pixel[23:16], s_pixel[7:0]};
`else
  assign w_pix = s_pixel;
`endif

  assign w_pix_end = (r_state == LOW) && w_done && (r_bit_idx == 5'd0);
  assign s_ready   = !rst && ((r_state == IDLE) || (w_pix_end && !r_last));
  assign w_xfer    = s_valid && s_ready;

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_value = L_T0H;
    case (r_state)
      IDLE: begin
        if (w_xfer) begin
          w_next  = HIGH;
          w_load  = 1'b1;
          w_value = w_pix[23] ? L_T1H : L_T0H;
        end
      end
      HIGH: begin
        if (w_done) begin
          w_next  = LOW;
          w_load  = 1'b1;
          w_value = r_shreg[23] ? L_T1L : L_T0L;
        end
      end
      LOW: begin
        if (w_done) begin
          if (r_bit_idx != 5'd0) begin
            w_next  = HIGH;
            w_load  = 1'b1;
            w_value = r_shreg[22] ? L_T1H : L_T0H;
          end else if (r_last) begin
            w_next  = LATCH;
            w_load  = 1'b1;
            w_value = L_TRS;
          end else if (w_xfer) begin
            w_next  = HIGH;
            w_load  = 1'b1;
            w_value = w_pix[23] ? L_T1H : L_T0H;
          end else begin
            w_next = IDLE;
          end
        end
      end
      LATCH: begin
        if (w_done) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_dout    <= 1'b0;
      r_shreg   <= '0;
      r_bit_idx <= 5'd0;
      r_last    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_dout  <= (w_next == HIGH);
      if (w_xfer) begin
        r_shreg   <= w_pix;
        r_bit_idx <= 5'd23;
        r_last    <= s_last;
      end else if ((r_state == LOW) && w_done && (r_bit_idx != 5'd0)) begin
        r_shreg   <= {r_shreg[22:0], 1'b0};
        r_bit_idx <= r_bit_idx - 5'd1;
      end
    end
  end

  ws2812_phase_timer #(
    .W (CW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_value (w_value),
    .i_tick  (1'b1),
    .o_done  (w_done)
  );

  assign dout = r_dout;
  assign busy = (r_state != IDLE);

endmodule
